// File: rtl/d_flip_flop_reg.sv
// Parameterised D-type register: STAGES cascaded flops of WIDTH bits with a
// synchronous active-high reset that loads RESET_VALUE into every stage.
module d_flip_flop_reg #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               STAGES      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reject unsupported geometries at elaboration rather than building odd hardware.
    generate
        if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
            $error("d_flip_flop_reg: WIDTH=%0d outside 1..1024", WIDTH);
        end
        if (STAGES < 1 || STAGES > 16) begin : g_bad_stages
            $error("d_flip_flop_reg: STAGES=%0d outside 1..16", STAGES);
        end
    endgenerate

    logic [WIDTH-1:0] s [STAGES];

    // NOTE: every stage is reset, not just the output one, so no stale
    // in-flight data can surface on q after rst is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            s[0] <= RESET_VALUE;
        end else begin
            // NOTE: non-blocking assignment keeps each stage sampling the
            // pre-edge value of its predecessor, which is what makes a shift chain.
            s[0] <= d;
        end
    end

    generate
        for (genvar g = 1; g < STAGES; g++) begin : g_stage
            always_ff @(posedge clk) begin
                if (rst) begin
                    s[g] <= RESET_VALUE;
                end else begin
                    s[g] <= s[g-1];
                end
            end
        end
    endgenerate

    assign q = s[STAGES-1];

endmodule

// File: tb/tb_d_flip_flop_reg.sv
// Scoreboard bench for d_flip_flop_reg: default 1-bit cell, an 8-bit 3-stage
// pipeline with non-zero reset value, and a 32-bit single stage.
module tb_d_flip_flop_reg;

    logic        clk;
    logic        rst_a, d_a, q_a;
    logic        rst_b;
    logic [7:0]  d_b, q_b;
    logic        rst_c;
    logic [31:0] d_c, q_c;

    int errors = 0;
    int checks = 0;

    // Expected q values, pushed when the stimulus for an edge is driven.
    logic [31:0] sb_a[$];
    logic [31:0] sb_b[$];
    logic [31:0] sb_c[$];

    d_flip_flop_reg dut_a (
        .clk (clk),
        .rst (rst_a),
        .d   (d_a),
        .q   (q_a)
    );

    d_flip_flop_reg #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5),
        .STAGES      (3)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .d   (d_b),
        .q   (q_b)
    );

    d_flip_flop_reg #(
        .WIDTH (32)
    ) dut_c (
        .clk (clk),
        .rst (rst_c),
        .d   (d_c),
        .q   (q_c)
    );

    // 10 ns period, first rising edge at 5 ns.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got t=%0t required finish earlier", $time);
        $fatal(1);
    end

    task automatic test_reset();
        logic        r_tab [2] = '{1'b1, 1'b0};
        logic [31:0] exp;
        for (int i = 0; i < 2; i++) begin
            if (i > 0) @(negedge clk);
            rst_a = r_tab[i];
            d_a   = 1'b0;
            sb_a.push_back(32'd0);
            @(posedge clk);
            #1;
            exp = sb_a.pop_front();
            checks++;
            if (q_a !== exp[0]) begin
                errors++;
                $display("FAIL reset_capture[%0d]: q=%b required %b", i, q_a, exp[0]);
            end
        end
    endtask

    task automatic test_toggle();
        logic        d_tab [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [31:0] exp;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            rst_a = 1'b0;
            d_a   = d_tab[i];
            sb_a.push_back({31'd0, d_tab[i]});
            @(posedge clk);
            #1;
            exp = sb_a.pop_front();
            checks++;
            if (q_a !== exp[0]) begin
                errors++;
                $display("FAIL toggle[%0d]: q=%b required %b", i, q_a, exp[0]);
            end
        end
    endtask

    task automatic test_reset_override();
        logic        r_tab [2] = '{1'b1, 1'b0};
        logic [31:0] exp;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst_a = r_tab[i];
            d_a   = 1'b1;
            sb_a.push_back(r_tab[i] ? 32'd0 : 32'd1);
            @(posedge clk);
            #1;
            exp = sb_a.pop_front();
            checks++;
            if (q_a !== exp[0]) begin
                errors++;
                $display("FAIL reset_override[%0d]: q=%b required %b", i, q_a, exp[0]);
            end
        end
    endtask

    task automatic test_between_edges();
        logic [31:0] exp;
        // Settle q=0, then pulse d inside the low phase.
        @(negedge clk);
        rst_a = 1'b0;
        d_a   = 1'b0;
        sb_a.push_back(32'd0);
        @(posedge clk);
        #1;
        exp = sb_a.pop_front();
        checks++;
        if (q_a !== exp[0]) begin
            errors++;
            $display("FAIL d_pulse_setup: q=%b required %b", q_a, exp[0]);
        end
        @(negedge clk);
        #1 d_a = 1'b1;
        sb_a.push_back(32'd0);
        #1;
        exp = sb_a.pop_front();
        checks++;
        if (q_a !== exp[0]) begin
            errors++;
            $display("FAIL d_pulse_mid: q=%b required %b", q_a, exp[0]);
        end
        #1 d_a = 1'b0;
        sb_a.push_back(32'd0);
        @(posedge clk);
        #1;
        exp = sb_a.pop_front();
        checks++;
        if (q_a !== exp[0]) begin
            errors++;
            $display("FAIL d_pulse_after: q=%b required %b", q_a, exp[0]);
        end
        // Settle q=1, then pulse rst between edges.
        @(negedge clk);
        d_a = 1'b1;
        sb_a.push_back(32'd1);
        @(posedge clk);
        #1;
        exp = sb_a.pop_front();
        checks++;
        if (q_a !== exp[0]) begin
            errors++;
            $display("FAIL rst_pulse_setup: q=%b required %b", q_a, exp[0]);
        end
        @(negedge clk);
        #1 rst_a = 1'b1;
        sb_a.push_back(32'd1);
        #1;
        exp = sb_a.pop_front();
        checks++;
        if (q_a !== exp[0]) begin
            errors++;
            $display("FAIL rst_pulse_mid: q=%b required %b", q_a, exp[0]);
        end
        #1 rst_a = 1'b0;
        sb_a.push_back(32'd1);
        @(posedge clk);
        #1;
        exp = sb_a.pop_front();
        checks++;
        if (q_a !== exp[0]) begin
            errors++;
            $display("FAIL rst_pulse_after: q=%b required %b", q_a, exp[0]);
        end
    endtask

    task automatic test_pipeline();
        // Columns: rst, d, expected q after the edge (3-edge latency, reset 8'hA5).
        logic       r_tab [11] = '{1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        logic [7:0] d_tab [11] = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                                   8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        logic [7:0] e_tab [11] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h01, 8'h02,
                                   8'h03, 8'hA5, 8'hA5, 8'hA5, 8'h07};
        logic [31:0] exp;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            rst_b = r_tab[i];
            d_b   = d_tab[i];
            sb_b.push_back({24'd0, e_tab[i]});
            @(posedge clk);
            #1;
            exp = sb_b.pop_front();
            checks++;
            if (q_b !== exp[7:0]) begin
                errors++;
                $display("FAIL pipeline[%0d]: q=%h required %h", i, q_b, exp[7:0]);
            end
        end
    endtask

    task automatic test_wide();
        logic        r;
        logic [31:0] v;
        logic [31:0] exp;
        for (int i = 0; i < 13; i++) begin
            if (i < 9) v = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0000_0000;
            else       v = $urandom;
            r = (i == 0);
            @(negedge clk);
            rst_c = r;
            d_c   = v;
            sb_c.push_back(r ? 32'd0 : v);
            @(posedge clk);
            #1;
            exp = sb_c.pop_front();
            checks++;
            if (q_c !== exp) begin
                errors++;
                $display("FAIL wide[%0d]: q=%h required %h", i, q_c, exp);
            end
        end
    endtask

    initial begin
        rst_a = 1'b1;
        d_a   = 1'b0;
        rst_b = 1'b1;
        d_b   = 8'h00;
        rst_c = 1'b1;
        d_c   = 32'h0;

        test_reset();
        test_toggle();
        test_reset_override();
        test_between_edges();
        test_pipeline();
        test_wide();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
